io_port_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller that replaces fixed switch/key/LED/7-segment glue on the single-cycle computer's data-memory bus. It synchronises switches, debounces keys and latches press events, holds LED and hex-digit registers, decodes digits to active-low 7-segment patterns, and raises a level interrupt on enabled key events. It sits beside data memory, claiming every access whose address falls in the IO_BASE page.

---
 rtl/io_port_ctrl.sv | 125 ++++++++++++
 tb/tb_io_port_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped switch/key/LED/7-segment controller with key-event interrupt
// clock, reset      : system clock, async active-high reset
// addr/wdata/we     : CPU data bus; rdata/hit return read data and page claim
// sw, key_n         : raw switches and active-low keys (asynchronous)
// led, hex, irq     : LED drive, active-low segments (digit i at [7i+6:7i]), interrupt
module io_port_ctrl #(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_FF00,
    parameter int          N_SW     = 10,
    parameter int          N_KEY    = 3,
    parameter int          N_LED    = 10,
    parameter int          N_HEX    = 6,
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    output logic [31:0]          rdata,
    output logic                 hit,
    input  logic [N_SW-1:0]      sw,
    input  logic [N_KEY-1:0]     key_n,
    output logic [N_LED-1:0]     led,
    output logic [7*N_HEX-1:0]   hex,
    output logic                 irq
);
    logic [N_SW-1:0]         sw_s1, sw_s2;
    logic [N_KEY-1:0]        key_s1, key_s2, level, level_nxt, key_edge, key_edge_nxt, irq_en, irq_en_nxt;
    logic [N_KEY-1:0][15:0]  cnt, cnt_nxt;
    logic [N_HEX-1:0][4:0]   hex_r;
    logic [N_LED-1:0]        led_r;
    logic [5:0]              off;
    logic                    wr;

    assign hit = addr[31:8] == IO_BASE[31:8];
    assign off = addr[7:2];
    assign wr  = we && hit;
    assign led = led_r;

    function automatic logic [6:0] seg(input logic [4:0] h);
        logic [6:0] s;
        case (h[3:0])
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return h[4] ? 7'h7F : s;
    endfunction

    for (genvar i = 0; i < N_HEX; i++) begin : g_hex
        assign hex[7*i +: 7] = seg(hex_r[i]);
    end

    // Debounce: count while the synchronised key disagrees with the accepted level;
    // toggle once the disagreement has lasted DEBOUNCE cycles.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        for (int k = 0; k < N_KEY; k++) begin
            level_nxt[k] = level[k] ^ ((~key_s2[k] != level[k]) && (cnt[k] == DEBOUNCE - 16'd1));
            cnt_nxt[k]   = ((~key_s2[k] != level[k]) && (cnt[k] != DEBOUNCE - 16'd1)) ? cnt[k] + 16'd1 : 16'd0;
        end
        irq_en_nxt   = (wr && off == 6'h03) ? wdata[N_KEY-1:0] : irq_en;
        // New press events are OR-ed after the W1C mask so a same-cycle set wins.
        key_edge_nxt = (key_edge & ~((wr && off == 6'h02) ? wdata[N_KEY-1:0] : '0)) | (level_nxt & ~level);
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                6'h00: rdata[N_SW-1:0]  = sw_s2;
                6'h01: rdata[N_KEY-1:0] = level;
                6'h02: rdata[N_KEY-1:0] = key_edge;
                6'h03: rdata[N_KEY-1:0] = irq_en;
                6'h04: rdata[N_LED-1:0] = led_r;
                default: rdata = '0;
            endcase
            for (int i = 0; i < N_HEX; i++)
                if (off == 6'(8 + i)) rdata[4:0] = hex_r[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            key_s1   <= '1;
            key_s2   <= '1;
            level    <= '0;
            cnt      <= '0;
            key_edge <= '0;
            irq_en   <= '0;
            led_r    <= '0;
            hex_r    <= {N_HEX{5'h10}};
            irq      <= 1'b0;
        end else begin
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            key_s1   <= key_n;
            key_s2   <= key_s1;
            level    <= level_nxt;
            cnt      <= cnt_nxt;
            key_edge <= key_edge_nxt;
            irq_en   <= irq_en_nxt;
            irq      <= |(key_edge_nxt & irq_en_nxt);
            if (wr && off == 6'h04) led_r <= wdata[N_LED-1:0];
            for (int i = 0; i < N_HEX; i++)
                if (wr && off == 6'(8 + i)) hex_r[i] <= wdata[4:0];
        end
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed self-checking bench for io_port_ctrl with a short debounce
module tb_io_port_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'hFFFF_FF00;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic [9:0]  sw = '0;
    logic [2:0]  key_n = '1;
    logic [9:0]  led;
    logic [41:0] hex;
    logic        irq;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] d;
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_port_ctrl #(.DEBOUNCE(16'd4)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .hit(hit), .sw(sw), .key_n(key_n), .led(led), .hex(hex), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clock);
        addr = a; wdata = v; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        @(negedge clock);
        addr = a;
        #1 v = rdata;
    endtask

    task automatic do_reset();
        key_n = '1; sw = '0; we = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (led !== 10'h0) begin errors++; $display("FAIL reset_led got %h exp 000", led); end
        checks++; if (hex !== {6{7'h7F}}) begin errors++; $display("FAIL reset_hex got %h exp %h", hex, {6{7'h7F}}); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        rd(32'hFFFF_FF04, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_key_level got %h exp 0", d); end
        rd(32'hFFFF_FF08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_key_edge got %h exp 0", d); end
        rd(32'hFFFF_FF0C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_irq_en got %h exp 0", d); end
        rd(32'hFFFF_FF20, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL reset_hex0_reg got %h exp 10", d); end
    endtask

    task automatic test_writes();
        wr(32'hFFFF_FF10, 32'h3FF);
        checks++; if (led !== 10'h3FF) begin errors++; $display("FAIL led_write got %h exp 3ff", led); end
        wr(32'hFFFF_FF20, 32'h0A);
        checks++; if (hex[6:0] !== 7'h08) begin errors++; $display("FAIL hex0_A got %h exp 08", hex[6:0]); end
        wr(32'hFFFF_FF20, 32'h1A);
        checks++; if (hex[6:0] !== 7'h7F) begin errors++; $display("FAIL hex0_blank got %h exp 7f", hex[6:0]); end
        rd(32'hFFFF_FF20, d);
        checks++; if (d !== 32'h1A) begin errors++; $display("FAIL hex0_read got %h exp 1a", d); end
        wr(32'hFFFF_FF80, 32'hFFFF_FFFF);
        rd(32'hFFFF_FF80, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
        checks++; if (led !== 10'h3FF || hex !== {{5{7'h7F}}, 7'h7F}) begin errors++; $display("FAIL unmapped_write led %h hex %h", led, hex); end
        rd(32'hFFFF_FF10, d);
        checks++; if (d !== 32'h3FF) begin errors++; $display("FAIL led_read got %h exp 3ff", d); end
        rd(32'h0000_1010, d);
        checks++; if (hit !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL miss hit %b rdata %h exp 0 0", hit, d); end
        wr(32'h0000_1010, 32'h0);
        checks++; if (led !== 10'h3FF) begin errors++; $display("FAIL miss_write led %h exp 3ff", led); end
    endtask

    task automatic test_debounce();
        do_reset();
        @(negedge clock);
        addr = 32'hFFFF_FF04;
        key_n[0] = 1'b0;
        repeat (3) @(negedge clock);
        key_n[0] = 1'b1;
        repeat (8) @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_level got %h exp 0", rdata); end
        key_n[0] = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL level_5_edges got %h exp 0", rdata); end
        @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL level_6_edges got %h exp 1", rdata); end
        addr = 32'hFFFF_FF08;
        #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL edge_on_press got %h exp 1", rdata); end
        key_n[0] = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL edge_after_release got %h exp 1", rdata); end
        addr = 32'hFFFF_FF04;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL level_after_release got %h exp 0", rdata); end
    endtask

    task automatic test_w1c_irq();
        do_reset();
        wr(32'hFFFF_FF0C, 32'h1);
        key_n[0] = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        @(negedge clock);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
        wr(32'hFFFF_FF08, 32'h0);
        rd(32'hFFFF_FF08, d);
        checks++; if (d !== 32'h1 || irq !== 1'b1) begin errors++; $display("FAIL w1c_zero edge %h irq %b exp 1 1", d, irq); end
        wr(32'hFFFF_FF08, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
        rd(32'hFFFF_FF08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", d); end
        key_n[0] = 1'b1;
        key_n[2] = 1'b0;
        repeat (10) @(negedge clock);
        rd(32'hFFFF_FF08, d);
        checks++; if (d !== 32'h4 || irq !== 1'b0) begin errors++; $display("FAIL disabled_key edge %h irq %b exp 4 0", d, irq); end
    endtask

    task automatic test_collision();
        do_reset();
        @(negedge clock);
        key_n[1] = 1'b0;
        repeat (5) @(negedge clock);
        addr = 32'hFFFF_FF08; wdata = 32'h2; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
        #1;
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL collision_edge got %h exp 2", rdata); end
        addr = 32'hFFFF_FF04;
        #1;
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL collision_level got %h exp 2", rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(32'hFFFF_FF10, 32'h155);
        key_n[2] = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (led !== 10'h0) begin errors++; $display("FAIL async_reset_led got %h exp 000", led); end
        @(negedge clock);
        reset = 1'b0;
        addr = 32'hFFFF_FF04;
        repeat (5) @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL partial_discard got %h exp 0", rdata); end
        @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL redebounce got %h exp 4", rdata); end
        key_n[2] = 1'b1;
    endtask

    task automatic test_switches();
        do_reset();
        @(negedge clock);
        addr = 32'hFFFF_FF00;
        sw = 10'h2A5;
        @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sw_1_edge got %h exp 0", rdata); end
        @(negedge clock);
        #1;
        checks++; if (rdata !== 32'h2A5) begin errors++; $display("FAIL sw_2_edges got %h exp 2a5", rdata); end
    endtask

    task automatic test_hex_sweep();
        for (int i = 0; i < 16; i++) begin
            wr(32'hFFFF_FF34, 32'(i));
            checks++; if (hex[41:35] !== glyph[i]) begin errors++; $display("FAIL hex5_digit_%0d got %h exp %h", i, hex[41:35], glyph[i]); end
        end
        checks++; if (hex[34:0] !== {5{7'h7F}}) begin errors++; $display("FAIL hex_others got %h exp all 7f", hex[34:0]); end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_debounce();
        test_w1c_irq();
        test_collision();
        test_reset_mid();
        test_switches();
        test_hex_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
